score_display_ctrl: RTL
=======================

# score_display_ctrl

Score keeper and display sequencer for Pong. Counts points for two players as 2-digit BCD, detects the win, and produces the 16-bit hex word that drives the 4-digit multiplexed seven-segment display: P1 score on the left two digits, P2 on the right. After a win it alternates between the final score and a winner pattern until a new game starts.

## Interface
- `WIN_SCORE`, default 8'h11: winning score as 2-digit BCD. Low nibble must be 0..9 and the value must be nonzero.
- `BLINK_CYCLES`, default 25_000_000: length of one blink phase in `clk` cycles, ≥2 (0.5 s at 50 MHz).
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low. Release is assumed synchronised upstream.
- `new_game` input, 1 bit: single-cycle pulse that clears the scores and starts play.
- `point_p1` input, 1 bit: single-cycle pulse, P1 scores one point.
- `point_p2` input, 1 bit: single-cycle pulse, P2 scores one point.
- `display_value` output, 16 bits, registered: [15:8] P1 BCD, [7:0] P2 BCD, or a pattern.
- `game_over` output, 1 bit, registered: high while in OVER.
- `winner` output, 1 bit, registered: 0 = P1, 1 = P2. Valid only while `game_over` is high.

## Operation
- **States:** IDLE, PLAY, OVER.
- **Reset:**
  - State goes to IDLE.
  - Both scores = 8'h00.
  - `display_value` = 16'h0000, `game_over` = 0, `winner` = 0.
  - Blink timer = 0, blink phase = 0.
- **IDLE:**
  - Point pulses are ignored.
  - `new_game` → PLAY with both scores at 0.
- **PLAY:**
  - `point_p1` adds 1 to the P1 BCD score; `point_p2` adds 1 to the P2 BCD score.
  - BCD rule: ones 9 → 0 with a carry into tens. A score of 8'h99 saturates and does not wrap.
  - Simultaneous `point_p1` and `point_p2`: both are counted in the same cycle.
  - Win check uses the post-increment scores. If a score equals `WIN_SCORE`, go to OVER.
  - If both players reach `WIN_SCORE` in the same cycle, P1 wins.
- **OVER:**
  - Scores are frozen and point pulses are ignored.
  - Phase 0 shows the score. Phase 1 shows the winner pattern: 16'hAAAA for P1, 16'hBBBB for P2.
  - Timer counts 0..BLINK_CYCLES-1. At the terminal count it wraps to 0 and the phase toggles.
- **`new_game` has priority over everything, in any state:**
  - Scores clear, next state is PLAY, timer and phase clear.
  - Point pulses in the same cycle are discarded.
- **Output selection:** `display_value` is the score in IDLE, in PLAY, and in OVER phase 0; it is the winner pattern in OVER phase 1.

## Timing
- A point pulse sampled at edge N appears in `display_value` after edge N; one cycle of latency.
- The winning point, `game_over`=1 and `winner` all update after the same edge. The final score is shown in that cycle.
- First pattern phase starts exactly BLINK_CYCLES cycles after OVER entry. Every later phase also lasts exactly BLINK_CYCLES cycles.
- `new_game` at edge N gives `display_value`=16'h0000 and `game_over`=0 after edge N.
- Reset asserted mid-game clears all outputs immediately, without waiting for `clk`.
- Timer width is $clog2(BLINK_CYCLES).

## Structure
- **Shared package `pong_pkg`:**
  - state enum (IDLE, PLAY, OVER)
  - P1_WIN_PATTERN = 16'hAAAA, P2_WIN_PATTERN = 16'hBBBB
  - `score_t` = 8-bit BCD
- **Sub-module `bcd2_counter`:** instantiated twice.
  - Ports: `clk`, `rst_n`, `clr`, `inc`, `q[7:0]`; 2-digit BCD, saturating at 99.
  - `clr` takes priority over `inc`.
- Top level holds the FSM, win compare, blink timer/phase and output register. Target size is about 150–250 lines.

## Test plan
- Reset, then `new_game`, then 10 `point_p1` pulses → `display_value`=16'h1000 (BCD carry). Then 1 `point_p2` → 16'h1001.
- From 16'h1009, one `point_p1` → 16'h1109, `game_over`=1, `winner`=0. After BLINK_CYCLES (set to 4) → 16'hAAAA; after 4 more → 16'h1109.
- From 16'h1010, simultaneous `point_p1` and `point_p2` → 16'h1111, `winner`=0 (tie-break to P1).
- In OVER, and separately in IDLE, `point_p2` pulses → `display_value` unchanged. `new_game` together with `point_p1` in OVER → 16'h0000, PLAY, `game_over`=0.
- With WIN_SCORE=8'h99, drive P2 to 8'h98 in PLAY, then `point_p2` → 16'h0099 and OVER. Separately, `bcd2_counter` unit check: at 99, `inc` holds at 99.
- Assert `rst_n` low mid-blink, asynchronously between edges → outputs go to 0 immediately. After release, the block sits in IDLE and ignores points.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong score/display logic.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef logic [7:0] score_t;

    localparam logic [15:0] P1_WIN_PATTERN = 16'hAAAA;
    localparam logic [15:0] P2_WIN_PATTERN = 16'hBBBB;
    localparam score_t      BCD_MAX        = 8'h99;

    // Two-digit BCD increment that saturates at 99.
    function automatic score_t bcd_inc(input score_t s);
        score_t r;
        if (s == BCD_MAX) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_ctrl_bcd2_counter.sv
// Two-digit BCD up-counter, saturating at 99; clear wins over increment.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);

    score_t q_q;
    score_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = bcd_inc(q_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/score_display_ctrl.sv
// Pong score keeper: BCD scores, win detection and blinking display word.
module score_display_ctrl
    import pong_pkg::*;
#(
    parameter logic [7:0]  WIN_SCORE    = 8'h11,
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        point_p1,
    input  logic        point_p2,
    output logic [15:0] display_value,
    output logic        game_over,
    output logic        winner
);

    localparam int unsigned     TW         = $clog2(BLINK_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(BLINK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          phase_q, phase_d;
    logic [15:0]   display_q, display_d;
    logic          game_over_q, game_over_d;
    logic          winner_q, winner_d;

    score_t p1_score, p2_score;
    score_t p1_next, p2_next;
    logic   p1_inc, p2_inc;

    assign p1_inc = (state_q == PLAY) && point_p1 && !new_game;
    assign p2_inc = (state_q == PLAY) && point_p2 && !new_game;

    bcd2_counter u_p1_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (new_game),
        .inc   (p1_inc),
        .q     (p1_score)
    );

    bcd2_counter u_p2_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (new_game),
        .inc   (p2_inc),
        .q     (p2_score)
    );

    // Post-increment view of the scores, so the win and the winning point land on the same edge.
    assign p1_next = p1_inc ? bcd_inc(p1_score) : p1_score;
    assign p2_next = p2_inc ? bcd_inc(p2_score) : p2_score;

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        phase_d     = 1'b0;
        display_d   = {p1_score, p2_score};
        game_over_d = 1'b0;
        winner_d    = winner_q;

        if (new_game) begin
            state_d   = PLAY;
            display_d = '0;
            winner_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                PLAY: begin
                    display_d = {p1_next, p2_next};
                    if (p1_next == WIN_SCORE) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b0;
                    end else if (p2_next == WIN_SCORE) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b1;
                    end
                end
                OVER: begin
                    game_over_d = 1'b1;
                    phase_d     = phase_q;
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (phase_d) begin
                        display_d = winner_q ? P2_WIN_PATTERN : P1_WIN_PATTERN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            phase_q     <= 1'b0;
            display_q   <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            display_q   <= display_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign display_value = display_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule
